// File: rtl/divider_control_if.sv
// Control handshake between the divider sequencer and its datapath.
// master is the sequencer side; slave is the datapath/requester side.
interface divider_control_if;
  logic       start;
  logic       sign;
  logic       load;
  logic       add;
  logic       shift;
  logic       inbit;
  logic [1:0] sel;
  logic       busy;
  logic       done;

  modport master (
    input  start,
    input  sign,
    output load,
    output add,
    output shift,
    output inbit,
    output sel,
    output busy,
    output done
  );

  modport slave (
    output start,
    output sign,
    input  load,
    input  add,
    input  shift,
    input  inbit,
    input  sel,
    input  busy,
    input  done
  );
endinterface

// File: rtl/divider_control.sv
// Sequencer for the 8-bit by 7-bit restoring divider datapath.
// Outputs are registered from the next state so they are glitch-free.
module divider_control (
  input  logic               clk,
  input  logic               reset,
  divider_control_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SUB,
    RESTORE,
    SETBIT,
    DONE
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [2:0] cnt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.start) nxt = LOAD;
      LOAD:    nxt = SUB;
      SUB:     nxt = bus.sign ? RESTORE : SETBIT;
      RESTORE,
      SETBIT:  nxt = (cnt == 3'd0) ? DONE : SUB;
      DONE:    nxt = bus.start ? LOAD : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      bus.load  <= 1'b0;
      bus.add   <= 1'b0;
      bus.shift <= 1'b0;
      bus.inbit <= 1'b0;
      bus.sel   <= 2'b11;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      state <= nxt;

      if (nxt == LOAD)
        cnt <= 3'd7;
      else if ((state == RESTORE || state == SETBIT)
               && cnt != 3'd0)
        cnt <= cnt - 3'd1;

      // hold pattern: remainder register recirculates
      bus.load  <= 1'b0;
      bus.add   <= 1'b0;
      bus.shift <= 1'b0;
      bus.inbit <= 1'b0;
      bus.sel   <= 2'b11;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;

      unique case (nxt)
        LOAD: begin
          bus.load  <= 1'b1;
          bus.sel   <= 2'b10;
          bus.shift <= 1'b1;
          bus.busy  <= 1'b1;
        end
        SUB: begin
          bus.sel  <= 2'b01;
          bus.busy <= 1'b1;
        end
        RESTORE: begin
          bus.add   <= 1'b1;
          bus.sel   <= 2'b01;
          bus.shift <= 1'b1;
          bus.busy  <= 1'b1;
        end
        SETBIT: begin
          bus.shift <= 1'b1;
          bus.inbit <= 1'b1;
          bus.busy  <= 1'b1;
        end
        DONE:    bus.done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/divider_control.md
# divider_control

Sequencing FSM for the 8-bit-by-7-bit restoring divider. Sits beside `datapath` and drives its `load`/`add`/`shift`/`inbit`/`sel` controls from the adder `sign` it returns. Accepts a one-cycle `start`, runs 8 restoring iterations and pulses `done` once `quotient`/`remainder` are valid. The controller never touches operand or result buses.

## Interface
- ITERATIONS, 8, quotient bits produced; fixed to the 8-bit dividend width; counter is 3 bits.
- clk  input  1  rising-edge clock, shared with `datapath`.
- reset  input  1  synchronous, active-high; same net as the `datapath` reset.
- start  input  1  request a division; sampled only in IDLE or DONE.
- sign  input  1  `datapath` adder result bit 7; 1 means the trial subtraction went negative.
- load  output  1  loads the divisor register in `datapath`.
- add  output  1  1 selects add, 0 selects subtract.
- shift  output  1  shifts the mux output left 1 before the remainder register.
- inbit  output  1  bit shifted into remainder[0].
- sel  output  2  mux select: 2'b01 = {adder, R[7:0]}; 2'b10 = {8'h00, dividendin}; 2'b11 = hold R. 2'b00 is never driven.
- busy  output  1  high in LOAD, SUB, RESTORE and SETBIT.
- done  output  1  one-cycle pulse; results valid.

## Operation
- States: IDLE, LOAD, SUB, RESTORE, SETBIT, DONE. 3-bit iteration counter `cnt`.
- Default (hold) outputs in IDLE and DONE: load=0, add=0, shift=0, inbit=0, sel=2'b11. The remainder register then recirculates unchanged.
- IDLE: start=1 -> LOAD; otherwise stay.
- LOAD:
  - Outputs: load=1, sel=2'b10, shift=1, inbit=0.
  - Effect: divisor register <= {0, divisorin}; R <= {8'h00, dividendin} << 1.
  - Sets cnt=7. Next state is SUB.
- SUB:
  - Outputs: add=0, sel=2'b01, shift=0.
  - Effect: R[15:8] <= R[15:8] - D.
  - Next state uses `sign` sampled at this edge: sign=1 -> RESTORE; sign=0 -> SETBIT.
- RESTORE:
  - Outputs: add=1, sel=2'b01, shift=1, inbit=0.
  - Effect: R <= {R[15:8] + D, R[7:0]} << 1 with a 0 inserted.
- SETBIT:
  - Outputs: sel=2'b11, shift=1, inbit=1.
  - Effect: R <= R << 1 with a 1 inserted.
- After RESTORE or SETBIT:
  - cnt != 0: decrement cnt and go to SUB.
  - cnt == 0: go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE. start=1 in DONE goes directly to LOAD for back-to-back operation.
- Results:
  - quotient = R[7:0].
  - remainder = R[15:9]; the final shift leaves the remainder one bit high.
  - The initial 0 shifted in at LOAD ends at R[8] and is ignored.
- Arithmetic range:
  - R[15:8] < 2D before each SUB, so a non-negative difference is <= 126 and has bit7=0.
  - A negative difference is >= -127 and has bit7=1.
  - `sign` is therefore exact for all 7-bit divisors.
- Divide by zero: no error flag. Every SUB is non-negative, giving quotient=8'hFF and remainder=dividendin[6:0].
- start while busy: ignored, not queued.
- reset mid-operation: next state IDLE, cnt=0, all outputs at reset values; `datapath` clears R and D on the same edge.

## Timing
- Reset values: load=0, add=0, shift=0, inbit=0, sel=2'b11, busy=0, done=0; state IDLE.
- All outputs are decoded from registered state and are glitch-free at the edge. Next-state logic is the only consumer of combinational `sign`.
- Operand capture:
  - dividendin and divisorin are captured at the edge ending the LOAD cycle (the cycle after start is sampled).
  - Upstream must hold both stable through that cycle.
- Latency: start sampled at edge E0 -> LOAD in cycle E0..E1 -> 16 iteration cycles -> DONE (done=1) in cycle E17..E18.
- Fixed 18-cycle occupancy from LOAD through DONE, independent of operand values.
- Results stay valid in IDLE until the next LOAD edge.

## Test plan
- Reset during idle, then release -> all outputs at reset values; start=1 -> LOAD one cycle later with load=1, sel=2'b10.
- 100 / 7 -> done exactly 17 cycles after the start edge; quotient=8'h0E, remainder=7'h02; busy high for 17 cycles.
- Edge operands:
  - 255 / 127 -> q=8'h02, r=7'h01.
  - 0 / 5 -> q=8'h00, r=7'h00.
  - 5 / 100 -> q=8'h00, r=7'h05.
  - 255 / 1 -> q=8'hFF, r=7'h00.
- 77 / 0 -> q=8'hFF, r=7'h4D; FSM returns to IDLE normally.
- start held high through an operation, with start=1 in DONE -> no restart while busy; LOAD follows DONE directly; second result correct.
- reset asserted in the 9th cycle of an operation -> IDLE next edge; done never pulses; outputs at reset values; a new start gives a correct result.
- Exhaustive: random or full dividend × divisor 1..127 sweep against a reference model -> q = dvd / dvs, r = dvd % dvs for every pair.
